// File: rtl/ppi_bus_sequencer_if.sv
// Host command/response channel plus the 8255 control pins. DATA stays a plain
// inout on the sequencer so tristate resolution lives on a single net.
interface ppi_bus_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rd;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       cfg_done;
    logic [1:0] A;
    logic       READ;
    logic       WRITE;
    logic       CS;
    logic       PPI_RESET;

    modport master (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data, cfg_done,
        output A, READ, WRITE, CS, PPI_RESET
    );

    modport slave (
        output cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data, cfg_done,
        input  A, READ, WRITE, CS, PPI_RESET
    );
endinterface

// File: rtl/ppi_bus_sequencer.sv
// 8255 PPI bus master: reset pulse, boot control-word write, then single-beat
// host reads/writes with programmable setup/strobe/hold timing.
module ppi_bus_sequencer #(
    parameter logic [7:0] CFG_WORD   = 8'h9B,
    parameter int         RST_CYC    = 2,
    parameter int         SETUP_CYC  = 1,
    parameter int         STROBE_CYC = 2,
    parameter int         HOLD_CYC   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ppi_bus_sequencer_if.master  bus,
    inout  wire  [7:0]           ppi_data_io
);

    typedef enum logic [2:0] {
        S_PRST, S_BOOT, S_SETUP, S_STROBE, S_HOLD, S_IDLE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] lim;
    logic       last;
    logic       rd_q, rd_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       boot_q, boot_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       cfg_done_q, cfg_done_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       ppi_rst_q, ppi_rst_d;
    logic       oe_q, oe_d;
    logic       active_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_PRST;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            boot_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cfg_done_q  <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            ppi_rst_q   <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            boot_q      <= boot_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cfg_done_q  <= cfg_done_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            ppi_rst_q   <= ppi_rst_d;
            oe_q        <= oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        boot_d      = boot_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        cfg_done_d  = cfg_done_q;

        unique case (state_q)
            S_PRST:   lim = 4'(RST_CYC - 1);
            S_SETUP:  lim = 4'(SETUP_CYC - 1);
            S_STROBE: lim = 4'(STROBE_CYC - 1);
            S_HOLD:   lim = 4'(HOLD_CYC - 1);
            default:  lim = '0;
        endcase
        last = (cnt_q == lim);

        // Timed states share one counter that wraps to zero on the way out.
        if (state_q inside {S_PRST, S_SETUP, S_STROBE, S_HOLD})
            cnt_d = last ? '0 : cnt_q + 4'd1;

        unique case (state_q)
            S_PRST:   if (last) state_d = S_BOOT;
            S_BOOT: begin
                rd_d    = 1'b0;
                addr_d  = 2'b11;
                wdata_d = CFG_WORD;
                boot_d  = 1'b1;
                state_d = S_SETUP;
            end
            S_SETUP:  if (last) state_d = S_STROBE;
            S_STROBE: if (last) begin
                state_d = S_HOLD;
                if (rd_q) rsp_data_d = ppi_data_io;
            end
            S_HOLD:   if (last) begin
                state_d     = S_IDLE;
                rsp_valid_d = !boot_q;
                cfg_done_d  = cfg_done_q | boot_q;
            end
            S_IDLE:   if (bus.cmd_valid && cmd_ready_q) begin
                rd_d    = bus.cmd_rd;
                addr_d  = bus.cmd_addr;
                wdata_d = bus.cmd_wdata;
                boot_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_SETUP;
            end
            default:  state_d = S_PRST;
        endcase

        // Pin values follow the state being entered so they register with it.
        active_d    = state_d inside {S_SETUP, S_STROBE, S_HOLD};
        cs_n_d      = !active_d;
        rd_n_d      = !((state_d == S_STROBE) && rd_d);
        wr_n_d      = !((state_d == S_STROBE) && !rd_d);
        oe_d        = active_d && !rd_d;
        cmd_ready_d = (state_d == S_IDLE);
        ppi_rst_d   = (state_d == S_PRST);
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.cfg_done  = cfg_done_q;
    assign bus.A         = addr_q;
    assign bus.READ      = rd_n_q;
    assign bus.WRITE     = wr_n_q;
    assign bus.CS        = cs_n_q;
    assign bus.PPI_RESET = ppi_rst_q;
    assign ppi_data_io   = oe_q ? wdata_q : 8'bz;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Random/directed bench: a transaction-level model predicts each CS window,
// strobe placement, bus data, responses and boot behaviour.
module tb_ppi_bus_sequencer;
    localparam logic [7:0] CFG = 8'h9B;
    localparam int RC = 2, SC = 1, STC = 2, HC = 1;
    localparam int L  = SC + STC + HC;

    typedef struct {
        bit       boot;
        bit       rd;
        bit [1:0] addr;
        bit [7:0] wdata;
        bit [7:0] rval;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_p = 1'b1;
    logic [7:0] tb_rval = 8'h00;
    wire  [7:0] ppi_data;

    ppi_bus_sequencer_if bus();

    ppi_bus_sequencer #(
        .CFG_WORD(CFG), .RST_CYC(RC), .SETUP_CYC(SC), .STROBE_CYC(STC), .HOLD_CYC(HC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .ppi_data_io(ppi_data)
    );

    // The PPI answers reads while READ is low; an idle bus floats high.
    assign ppi_data = bus.READ ? 8'bz : tb_rval;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup pu (ppi_data[g]);
    end

    always #5 clk = ~clk;
    always @(posedge clk) rst_p <= rst;

    int   n_chk = 0, n_err = 0;
    txn_t exp_q[$];
    txn_t cur;
    bit   in_win = 0, in_prst = 0, boot_done = 0, ended;
    int   wlen = 0, prst_cnt = 0;
    logic [63:0] wr_m, rd_m, smask;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_p) begin
            chk("rst_cmd_ready", bus.cmd_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_data",  bus.rsp_data, 0);
            chk("rst_cfg_done",  bus.cfg_done, 0);
            chk("rst_A",         bus.A, 0);
            chk("rst_strobes",   {bus.READ, bus.WRITE, bus.CS}, 3'b111);
            chk("rst_ppi_reset", bus.PPI_RESET, 1);
            chk("rst_data_z",    ppi_data, 8'hFF);
        end
        if (rst) begin
            exp_q.delete();
            exp_q.push_back('{1'b1, 1'b0, 2'b11, CFG, 8'h00});
            in_win = 0; boot_done = 0; in_prst = 1; prst_cnt = 0;
        end else begin
            if (in_prst) begin
                if (bus.PPI_RESET) prst_cnt++;
                else begin
                    chk("prst_len", prst_cnt, RC);
                    in_prst = 0;
                end
            end else chk("ppi_reset_low", bus.PPI_RESET, 0);

            if (!rst_p) begin
                ended = 0;
                if (!bus.CS) begin
                    if (!in_win) begin
                        if (exp_q.size() == 0) begin
                            chk("spurious_window", 1, 0);
                            cur = '{1'b0, 1'b0, 2'b00, 8'h00, 8'h00};
                        end else cur = exp_q[0];
                        in_win = 1; wlen = 0; wr_m = '0; rd_m = '0;
                        tb_rval = cur.rval;
                    end
                    if (!bus.WRITE) wr_m[wlen] = 1'b1;
                    if (!bus.READ)  rd_m[wlen] = 1'b1;
                    chk("rw_exclusive", bus.READ | bus.WRITE, 1);
                    chk("win_A", bus.A, cur.addr);
                    chk("win_data", ppi_data,
                        cur.rd ? (bus.READ ? 8'hFF : cur.rval) : cur.wdata);
                    chk("win_ready", bus.cmd_ready, 0);
                    chk("win_rsp_valid", bus.rsp_valid, 0);
                    wlen++;
                end else begin
                    if (in_win) begin
                        ended = 1; in_win = 0;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        smask = ((64'd1 << STC) - 64'd1) << SC;
                        chk("win_len", wlen, L);
                        chk("write_strobe", wr_m, cur.rd ? 64'd0 : smask);
                        chk("read_strobe",  rd_m, cur.rd ? smask : 64'd0);
                        if (cur.boot) boot_done = 1;
                        else if (cur.rd) chk("rd_data", bus.rsp_data, cur.rval);
                    end
                    chk("idle_strobes", {bus.READ, bus.WRITE}, 2'b11);
                    chk("idle_data_z", ppi_data, 8'hFF);
                    chk("rsp_valid", bus.rsp_valid, ended && !cur.boot);
                    chk("cmd_ready", bus.cmd_ready, boot_done);
                end
                chk("cfg_done", bus.cfg_done, boot_done);
            end
        end
    end

    task automatic send(input bit rd, input bit [1:0] a, input bit [7:0] d, input bit [7:0] rv);
        bit acc = 0;
        bus.cmd_rd = rd; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk); acc = bus.cmd_ready;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        if (acc) exp_q.push_back('{1'b0, rd, a, d, rv});
        else chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && bus.cmd_ready;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit rd;
        bit [1:0] a;
        int nw;
        bit hit;
        bus.cmd_valid = 1'b0; bus.cmd_rd = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();
        chk("boot_cfg_done", bus.cfg_done, 1);

        send(1'b0, 2'b01, 8'd20, 8'd0);  wait_idle();
        send(1'b1, 2'b00, 8'd0, 8'd90);  wait_idle();
        chk("read_90", bus.rsp_data, 8'd90);
        send(1'b0, 2'b01, 8'd25, 8'd0);
        send(1'b1, 2'b10, 8'd0, 8'($urandom_range(0, 254)));
        wait_idle();
        send(1'b0, 2'b11, 8'h05, 8'd0);  wait_idle();

        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            a  = 2'($urandom_range(0, 3));
            send(rd, a, 8'($urandom_range(0, 254)), 8'($urandom_range(0, 254)));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_idle();

        // Abort a write in its second strobe cycle; boot must rerun.
        send(1'b0, 2'b10, 8'h3C, 8'd0);
        nw = 0; hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (!bus.WRITE) nw++;
            hit = (nw == 2);
        end
        if (!hit) chk("strobe2_timeout", 0, 1);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(1'b1, 2'b01, 8'd0, 8'($urandom_range(0, 254)));
        wait_idle();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
